// File: rtl/axi_zero_fill.sv
// axi_zero_fill: AXI4 manager that writes zeros over a contiguous region
// using INCR bursts. Bursts are capped at MaxBurstLen beats and never
// cross a 4 KiB page. At most MaxOutstanding AW handshakes may be waiting
// for their B response. No read traffic is ever issued.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   start_i       start request, only looked at while idle
//   addr_i        start byte address (low bits below the beat size are dropped)
//   len_i         number of beats to write
//   busy_o        high from the accepted start until done
//   done_o        one-cycle completion pulse
//   error_o       sticky SLVERR/DECERR indication, cleared by the next start
//   axi_req_o     AXI manager request
//   axi_resp_i    AXI manager response

package axi_zero_fill_pkg;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned UserWidth = 1;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;
endpackage

module axi_zero_fill #(
  parameter type         axi_req_t      = axi_zero_fill_pkg::axi_req_t,
  parameter type         axi_resp_t     = axi_zero_fill_pkg::axi_resp_t,
  parameter int unsigned AddrWidth      = axi_zero_fill_pkg::AddrWidth,
  parameter int unsigned DataWidth      = axi_zero_fill_pkg::DataWidth,
  parameter int unsigned IdWidth        = axi_zero_fill_pkg::IdWidth,
  parameter int unsigned MaxBurstLen    = 16,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [AddrWidth-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output axi_req_t             axi_req_o,
  input  axi_resp_t            axi_resp_i
);

  localparam int unsigned OffW = $clog2(DataWidth / 8);
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  // Width wide enough for both the remaining count and the 4 KiB page room.
  localparam int unsigned CW   = (AddrWidth > 13) ? AddrWidth : 13;
  localparam logic [AddrWidth-1:0] AlignMask =
    ~((AddrWidth'(1) << OffW) - AddrWidth'(1));
  localparam logic [IdWidth-1:0] AwId = '0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] remaining_q, remaining_d;
  logic [OutW-1:0]      outstanding_q, outstanding_d;
  logic                 aw_valid_q, aw_valid_d;
  logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]           aw_len_q, aw_len_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  // W length FIFO: one entry (burst length - 1) per accepted AW.
  logic [7:0]           fifo_mem_q [MaxOutstanding];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OutW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;

  logic                 aw_hs, w_hs, b_hs, w_valid, w_last, fifo_pop;
  logic [12:0]          page_left;
  logic [CW-1:0]        room, beats_w;
  logic [8:0]           burst_beats;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    aw_valid_d    = aw_valid_q;
    aw_addr_d     = aw_addr_q;
    aw_len_d      = aw_len_q;
    error_d       = error_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    beat_cnt_d    = beat_cnt_q;

    aw_hs    = aw_valid_q & axi_resp_i.aw_ready;
    w_valid  = (fifo_cnt_q != '0);
    w_last   = (beat_cnt_q == fifo_mem_q[rd_ptr_q]);
    w_hs     = w_valid & axi_resp_i.w_ready;
    b_hs     = axi_resp_i.b_valid;
    fifo_pop = w_hs & w_last;

    // Beats left before the next 4 KiB boundary; addr_q is beat aligned so
    // this is always at least one.
    page_left = 13'd4096 - {1'b0, addr_q[11:0]};
    room      = CW'(page_left >> OffW);
    beats_w   = CW'(MaxBurstLen);
    if (CW'(remaining_q) < beats_w) beats_w = CW'(remaining_q);
    if (room < beats_w)             beats_w = room;

    burst_beats = {1'b0, aw_len_q} + 9'd1;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          error_d = 1'b0;
          if (len_i != '0) begin
            state_d     = RUN;
            addr_d      = addr_i & AlignMask;
            remaining_d = len_i;
          end else begin
            state_d = DONE;
          end
        end
      end

      RUN: begin
        // AW is raised from registered state only, so its fields stay put
        // until the handshake; the address advances at the handshake.
        if (aw_hs) begin
          aw_valid_d  = 1'b0;
          addr_d      = addr_q + (AddrWidth'(burst_beats) << OffW);
          remaining_d = remaining_q - AddrWidth'(burst_beats);
          wr_ptr_d    = ptr_inc(wr_ptr_q);
        end else if (!aw_valid_q && remaining_q != '0 &&
                     outstanding_q < OutW'(MaxOutstanding) &&
                     fifo_cnt_q < OutW'(MaxOutstanding)) begin
          aw_valid_d = 1'b1;
          aw_addr_d  = addr_q;
          aw_len_d   = beats_w[7:0] - 8'd1;
        end

        if (w_hs) begin
          if (w_last) begin
            beat_cnt_d = '0;
            rd_ptr_d   = ptr_inc(rd_ptr_q);
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end

        if (b_hs && axi_resp_i.b.resp[1]) error_d = 1'b1;

        unique case ({aw_hs, b_hs})
          2'b10:   outstanding_d = outstanding_q + OutW'(1);
          2'b01:   outstanding_d = outstanding_q - OutW'(1);
          default: outstanding_d = outstanding_q;
        endcase

        unique case ({aw_hs, fifo_pop})
          2'b10:   fifo_cnt_d = fifo_cnt_q + OutW'(1);
          2'b01:   fifo_cnt_d = fifo_cnt_q - OutW'(1);
          default: fifo_cnt_d = fifo_cnt_q;
        endcase

        if (remaining_q == '0 && fifo_cnt_q == '0 && outstanding_q == '0)
          state_d = DONE;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      aw_valid_q    <= 1'b0;
      aw_addr_q     <= '0;
      aw_len_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      aw_valid_q    <= aw_valid_d;
      aw_addr_q     <= aw_addr_d;
      aw_len_q      <= aw_len_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end

  // FIFO storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (aw_hs && state_q == RUN) fifo_mem_q[wr_ptr_q] <= aw_len_q;
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = AwId;
    axi_req_o.aw.addr  = aw_addr_q;
    axi_req_o.aw.len   = aw_len_q;
    axi_req_o.aw.size  = 3'(OffW);
    axi_req_o.aw.burst = 2'b01;
    axi_req_o.aw_valid = aw_valid_q;
    axi_req_o.w.data   = '0;
    axi_req_o.w.strb   = '1;
    axi_req_o.w.last   = w_last;
    axi_req_o.w_valid  = w_valid;
    axi_req_o.b_ready  = 1'b1;
    axi_req_o.ar_valid = 1'b0;
    axi_req_o.r_ready  = 1'b1;
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign error_o = error_q;

  // Read data, B id and the ready signals of unused channels are ignored.
  logic unused_resp;
  assign unused_resp = ^axi_resp_i;

endmodule

// File: tb/tb_axi_zero_fill.sv
// Testbench for axi_zero_fill (DataWidth 64, MaxBurstLen 16, MaxOutstanding 2).
// A reference model expands each request into the list of expected bursts and
// beats; a monitor compares every AW/W handshake against those queues while a
// subordinate model randomly stalls and returns B responses.
module tb_axi_zero_fill;
  localparam int MAX_OUT   = 2;
  localparam int MAX_BURST = 16;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] addr_in, len_in;
  logic        busy, done, err;
  axi_zero_fill_pkg::axi_req_t  req;
  axi_zero_fill_pkg::axi_resp_t resp;

  always #5 clk = ~clk;

  axi_zero_fill #(
    .MaxBurstLen(MAX_BURST),
    .MaxOutstanding(MAX_OUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .addr_i(addr_in), .len_i(len_in),
    .busy_o(busy), .done_o(done), .error_o(err),
    .axi_req_o(req), .axi_resp_i(resp)
  );

  logic       aw_ready_drv = 1'b0, w_ready_drv = 1'b0, b_valid_drv = 1'b0;
  logic [1:0] b_resp_drv = 2'b00;
  logic [3:0] b_id_drv = 4'h0;

  always_comb begin
    resp          = '0;
    resp.aw_ready = aw_ready_drv;
    resp.ar_ready = 1'b1;
    resp.w_ready  = w_ready_drv;
    resp.b_valid  = b_valid_drv;
    resp.b.resp   = b_resp_drv;
    resp.b.id     = b_id_drv;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues and per-operation counters.
  logic [31:0] exp_aw_addr[$];
  int          exp_aw_len[$];
  bit          exp_w_last[$];
  int aw_hs = 0, wlast_cnt = 0, b_done = 0, b_issued = 0, err_idx = -1;
  bit hold_b = 1'b0, stall_en = 1'b0;

  // Reference model: split [addr, addr+len beats) into bursts limited by
  // MAX_BURST and 4 KiB pages, with address wrapping at 2^32.
  task automatic plan_op(input logic [31:0] a0, input logic [31:0] n, output int nb);
    longint a, rem, room, b;
    a   = longint'(a0) & ~64'h7;
    rem = longint'(n);
    nb  = 0;
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / 8;
      b = rem;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > room)      b = room;
      exp_aw_addr.push_back(a[31:0]);
      exp_aw_len.push_back(int'(b - 1));
      for (longint i = 0; i < b; i++) exp_w_last.push_back(i == b - 1);
      a   = (a + b * 8) % 64'h1_0000_0000;
      rem = rem - b;
      nb++;
    end
  endtask

  // Subordinate model: random ready stalls, one B per completed W burst.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      aw_ready_drv = 1'b0;
      w_ready_drv  = 1'b0;
      b_valid_drv  = 1'b0;
      b_resp_drv   = 2'b00;
      b_issued     = 0;
      b_done       = 0;
    end else begin
      if (b_valid_drv) begin
        b_done++;
        b_valid_drv = 1'b0;
      end
      aw_ready_drv = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      w_ready_drv  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!hold_b && b_issued < wlast_cnt) begin
        b_valid_drv = 1'b1;
        b_resp_drv  = (b_issued == err_idx) ? 2'b10 : 2'b00;
        b_id_drv    = 4'($urandom);
        b_issued++;
      end
    end
  end

  // Monitor: compares handshakes with the scoreboard and checks stability.
  bit          aw_pend = 1'b0, w_pend = 1'b0, pend_w_last = 1'b0;
  logic [31:0] pend_aw_addr = '0;
  logic [7:0]  pend_aw_len = '0;

  always @(negedge clk) begin
    if (rst) begin
      aw_pend = 1'b0;
      w_pend  = 1'b0;
    end else begin
      check("static_channels", !req.ar_valid && req.r_ready && req.b_ready,
            {req.ar_valid, req.r_ready, req.b_ready}, 3'b011);
      if (aw_pend)
        check("aw_stable", req.aw_valid && req.aw.addr == pend_aw_addr && req.aw.len == pend_aw_len,
              {req.aw_valid, req.aw.addr}, {1'b1, pend_aw_addr});
      if (w_pend)
        check("w_stable", req.w_valid && req.w.last == pend_w_last,
              {req.w_valid, req.w.last}, {1'b1, pend_w_last});

      if (req.w_valid && w_ready_drv) begin
        check("w_after_aw", wlast_cnt < aw_hs, wlast_cnt, aw_hs);
        if (exp_w_last.size() == 0) begin
          check("w_unexpected", 1'b0, 1, 0);
        end else begin
          bit e;
          e = exp_w_last.pop_front();
          check("w_data_strb", req.w.data == '0 && req.w.strb == 8'hFF && req.w.user == '0,
                {req.w.strb, req.w.data[31:0]}, {8'hFF, 32'h0});
          check("w_last", req.w.last == e, req.w.last, e);
        end
        if (req.w.last) wlast_cnt++;
      end

      if (req.aw_valid && aw_ready_drv) begin
        check("aw_outstanding", (aw_hs - b_done) < MAX_OUT, aw_hs - b_done, MAX_OUT - 1);
        if (exp_aw_addr.size() == 0) begin
          check("aw_unexpected", 1'b0, req.aw.addr, 0);
        end else begin
          logic [31:0] ea;
          int el;
          ea = exp_aw_addr.pop_front();
          el = exp_aw_len.pop_front();
          check("aw_addr", req.aw.addr == ea, req.aw.addr, ea);
          check("aw_len", int'(req.aw.len) == el, req.aw.len, el);
          check("aw_fields", req.aw.size == 3'd3 && req.aw.burst == 2'b01 && req.aw.id == '0 &&
                req.aw.lock == 1'b0 && req.aw.cache == '0 && req.aw.prot == '0 &&
                req.aw.qos == '0 && req.aw.region == '0 && req.aw.atop == '0 && req.aw.user == '0,
                {req.aw.size, req.aw.burst}, {3'd3, 2'b01});
        end
        aw_hs++;
      end

      aw_pend      = req.aw_valid && !aw_ready_drv;
      pend_aw_addr = req.aw.addr;
      pend_aw_len  = req.aw.len;
      w_pend       = req.w_valid && !w_ready_drv;
      pend_w_last  = req.w.last;
    end
  end

  // Issue one start pulse; called only while the DUT is idle.
  task automatic start_op(input logic [31:0] a, input logic [31:0] n, output int nb);
    aw_hs = 0; wlast_cnt = 0; b_done = 0; b_issued = 0;
    plan_op(a, n, nb);
    start = 1'b1; addr_in = a; len_in = n;
    @(posedge clk); #2;
    start = 1'b0;
    check("busy_after_start", busy == (n != 0), busy, n != 0);
    check("error_cleared_on_start", err == 1'b0, err, 0);
  endtask

  task automatic wait_done(input int nb, input bit exp_err, input bit zero_len);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 20000);
    check("done_seen", done, done, 1);
    if (done) begin
      if (zero_len) check("len0_latency", t <= 2, t, 2);
      check("busy_low_at_done", !busy, busy, 0);
      check("error_at_done", err == exp_err, err, exp_err);
      check("aw_count", aw_hs == nb, aw_hs, nb);
      check("wlast_count", wlast_cnt == nb, wlast_cnt, nb);
      check("b_count", b_done == nb, b_done, nb);
      check("queues_empty", exp_aw_addr.size() == 0 && exp_w_last.size() == 0,
            exp_aw_addr.size() + exp_w_last.size(), 0);
      @(negedge clk);
      check("done_one_cycle", !done, done, 0);
    end
    exp_aw_addr.delete(); exp_aw_len.delete(); exp_w_last.delete();
    @(posedge clk); #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, t;
    rst = 1'b1; start = 1'b0; addr_in = '0; len_in = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", !busy && !done && !err && !req.aw_valid && !req.w_valid,
          {busy, done, err, req.aw_valid, req.w_valid}, 0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Basic split: 0x1000, 40 beats -> 16/16/8.
    start_op(32'h1000, 40, nb);
    wait_done(nb, 1'b0, 1'b0);

    // 4 KiB page crossing.
    start_op(32'h0FF0, 4, nb);
    wait_done(nb, 1'b0, 1'b0);

    // Outstanding limit with B held back.
    hold_b = 1'b1;
    start_op(32'h0, 64, nb);
    repeat (60) @(negedge clk);
    check("outstanding_cap", aw_hs == MAX_OUT, aw_hs, MAX_OUT);
    hold_b = 1'b0;
    wait_done(nb, 1'b0, 1'b0);

    // Error on the second B, held through idle, cleared by the next start.
    start_op(32'h1000, 40, nb);
    err_idx = 1;
    wait_done(nb, 1'b1, 1'b0);
    err_idx = -1;
    repeat (3) @(negedge clk);
    check("error_held_idle", err == 1'b1, err, 1);
    @(posedge clk); #2;
    start_op(32'h3000, 8, nb);
    wait_done(nb, 1'b0, 1'b0);

    // Zero length: done only, no AXI traffic.
    start_op(32'h1234, 0, nb);
    wait_done(nb, 1'b0, 1'b1);

    // Start during RUN must be ignored.
    stall_en = 1'b1;
    start_op(32'h8000, 50, nb);
    repeat (8) @(posedge clk);
    #2;
    start = 1'b1; addr_in = 32'h100; len_in = 5;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(nb, 1'b0, 1'b0);

    // Randomised operations with stalls, errors and an address wrap.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, n;
      bit e;
      a = (i == 0) ? 32'hFFFF_FF80 : $urandom;
      n = $urandom_range(1, 100);
      start_op(a, n, nb);
      err_idx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      e = (err_idx >= 0);
      wait_done(nb, e, 1'b0);
      err_idx = -1;
    end

    // Reset in the middle of an operation.
    start_op(32'h2000, 64, nb);
    t = 0;
    while (aw_hs < 1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("reset_trigger_reached", aw_hs >= 1, aw_hs, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_op", !req.aw_valid && !req.w_valid && !busy && !done && !err,
          {req.aw_valid, req.w_valid, busy, done, err}, 0);
    exp_aw_addr.delete(); exp_aw_len.delete(); exp_w_last.delete();
    #1;
    rst = 1'b0;
    @(posedge clk); #2;
    start_op(32'h40, 3, nb);
    wait_done(nb, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
